hw2_result_acc: RTL
===================

# hw2_result_acc

Downstream consumer of the 16-bit gated multiply-add result `d` (`(a+b)*c` or `(a-b)*c`). Collects results over a frame of N samples, tracks the unsigned sum, unsigned maximum and number of zero results (c = 0 cycles), then presents one frame summary on a valid/ready output. Throttles the producer with `in_ready` while a finished summary waits to be taken.

## Interface

- `N`, default 8: samples per frame, legal range 2..16.
- `DW`, default 16: input result width; must match producer `d`.
- `clk`  input  1  single clock, all state updates on rising edge.
- `reset`  input  1  synchronous, active-low; sampled on `clk` rising edge.
- `in_valid`  input  1  producer result valid.
- `in_data`  input  DW  producer result (`d`), unsigned.
- `in_ready`  output  1  block accepts `in_data` this cycle.
- `flush`  input  1  close current frame early (partial frame).
- `out_valid`  output  1  frame summary valid.
- `out_ready`  input  1  consumer takes summary.
- `out_sum`  output  DW+4  unsigned sum of frame samples.
- `out_max`  output  DW  largest sample in frame.
- `out_zeros`  output  5  count of samples equal to 0.
- `out_count`  output  5  samples in frame (N, or fewer on flush).

## Operation

- States: ACCUM, DONE.
- Accept = `in_valid && in_ready`.
- ACCUM: `in_ready` = 1. On accept: sum += in_data (zero-extended to DW+4), max = max(max, in_data), zeros += (in_data == 0), cnt += 1.
- Frame close in ACCUM when either: accept with cnt == N-1, or `flush` = 1 and (cnt > 0 or accept). An accepted sample in the flush cycle is included. On close: load out_* from the updated accumulator values, set `out_valid`, go to DONE, clear internal accumulators and cnt.
- `flush` with cnt == 0 and no accept: ignored. `flush` in DONE: ignored, not remembered.
- DONE: `in_ready` = 0, `in_valid` ignored (producer holds its data). out_* held stable. On `out_valid && out_ready`: clear `out_valid`, go to ACCUM.
- Width: DW+4 sum holds 16 × (2^DW − 1) without overflow; no wrap for legal N.
- Reset (`reset` = 0 at an edge): state ACCUM, cnt/sum/max/zeros = 0, `out_valid` = 0, out_sum/out_max/out_zeros/out_count = 0. Reset overrides any accept, flush, or handshake in the same cycle; a partial frame is discarded.

## Timing

- `in_ready` combinational from state: 1 in ACCUM, 0 in DONE; forced 0 while `reset` = 0.
- `out_valid` and out_* registered.
- Latency: closing accept at edge k → `out_valid` = 1 from edge k to the edge where `out_ready` is sampled 1.
- `out_ready` may already be 1 when `out_valid` rises; handoff happens on the next edge. `in_ready` = 1 the cycle after handoff.
- Minimum frame period N+1 cycles (N accepts + 1 DONE cycle).
- `out_ready` while `out_valid` = 0: no effect.

## Test plan

- Reset mid-frame: accept 3 samples, hold `reset` = 0 for 2 cycles → out_* = 0, `out_valid` = 0, `in_ready` = 0. After release, 8 samples of 1 → out_count = 8, out_sum = 8. Old samples must not appear.
- Full frame N = 8, in_data 1..8 back-to-back → `out_valid` after 8th accept; out_sum = 36, out_max = 8, out_zeros = 0, out_count = 8.
- Gated zeros: 8 samples of 0x0000 → out_sum = 0, out_max = 0, out_zeros = 8. Mixed 0,0x1234,0,0xFFFF,0,0,5,0 → out_sum = 0x11238, out_max = 0xFFFF, out_zeros = 5.
- Overflow bound: 8 × 0xFFFF → out_sum = 0x7FFF8, out_max = 0xFFFF.
- Backpressure: `out_ready` = 0 for 5 cycles after close, `in_valid` = 1 throughout → out_* stable, `in_ready` = 0, no samples accepted. Raise `out_ready` → next frame starts clean with cnt 0.
- Flush: accept 10, 0, 5 with `flush` = 1 on the third accept → out_count = 3, out_sum = 15, out_max = 10, out_zeros = 1. A later `flush` with no data → no `out_valid`.

Source files
------------

// File: rtl/hw2_result_acc_if.sv
// Handshake bundle between the multiply-add producer, the frame accumulator and
// the frame-summary consumer.
interface hw2_result_acc_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW+3:0] out_sum;
   logic [DW-1:0] out_max;
   logic [4:0]    out_zeros;
   logic [4:0]    out_count;

   modport master (
      output in_valid,
      output in_data,
      output flush,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_max,
      input  out_zeros,
      input  out_count
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  flush,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_max,
      output out_zeros,
      output out_count
   );
endinterface

// File: rtl/hw2_result_acc.sv
// Frame accumulator for the gated multiply-add result: sums, maxes and counts
// zero samples over N results, then hands one summary downstream.
module hw2_result_acc #(
   parameter int N  = 8,
   parameter int DW = 16
) (
   input  logic             clk,
   input  logic             reset,
   hw2_result_acc_if.slave  bus
);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   localparam logic [4:0] LAST_C = 5'(N - 1);

   state_t        state_r;
   state_t        state_nxt_s;

   logic          in_ready_s;
   logic          accept_s;
   logic          close_s;
   logic          handoff_s;
   logic          is_zero_s;

   logic [4:0]    cnt_r;
   logic [4:0]    cnt_nxt_s;
   logic [DW+3:0] sum_r;
   logic [DW+3:0] sum_nxt_s;
   logic [DW-1:0] max_r;
   logic [DW-1:0] max_nxt_s;
   logic [4:0]    zeros_r;
   logic [4:0]    zeros_nxt_s;

   logic          out_valid_r;
   logic [DW+3:0] out_sum_r;
   logic [DW-1:0] out_max_r;
   logic [4:0]    out_zeros_r;
   logic [4:0]    out_count_r;

   assign accept_s  = bus.in_valid && in_ready_s;
   assign handoff_s = out_valid_r && bus.out_ready;
   assign is_zero_s = (bus.in_data == {DW{1'b0}});

   // Frame close: last sample of a full frame, or flush with something to report
   always_comb begin
      close_s = 1'b0;
      if (state_r == ACCUM) begin
         close_s = (accept_s && (cnt_r == LAST_C)) ||
                   (bus.flush && ((cnt_r != 5'd0) || accept_s));
      end else begin
         close_s = 1'b0;
      end
   end

   // Accumulator values including the sample accepted this cycle
   always_comb begin
      sum_nxt_s   = sum_r;
      max_nxt_s   = max_r;
      zeros_nxt_s = zeros_r;
      cnt_nxt_s   = cnt_r;
      if (accept_s) begin
         sum_nxt_s   = sum_r + {4'b0000, bus.in_data};
         max_nxt_s   = (bus.in_data > max_r) ? bus.in_data : max_r;
         zeros_nxt_s = zeros_r + {4'b0000, is_zero_s};
         cnt_nxt_s   = cnt_r + 5'd1;
      end else begin
         sum_nxt_s   = sum_r;
         max_nxt_s   = max_r;
         zeros_nxt_s = zeros_r;
         cnt_nxt_s   = cnt_r;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ACCUM: begin
            if (close_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         DONE: begin
            if (handoff_s) begin
               state_nxt_s = ACCUM;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = ACCUM;
      endcase
   end

   // State-decoded outputs; in_ready is held low while reset is asserted
   always_comb begin
      in_ready_s = 1'b0;
      case (state_r)
         ACCUM:   in_ready_s = reset;
         DONE:    in_ready_s = 1'b0;
         default: in_ready_s = 1'b0;
      endcase
   end

   // Running accumulators, cleared whenever a frame closes
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r   <= 5'd0;
         sum_r   <= {(DW+4){1'b0}};
         max_r   <= {DW{1'b0}};
         zeros_r <= 5'd0;
      end else if (close_s) begin
         cnt_r   <= 5'd0;
         sum_r   <= {(DW+4){1'b0}};
         max_r   <= {DW{1'b0}};
         zeros_r <= 5'd0;
      end else begin
         cnt_r   <= cnt_nxt_s;
         sum_r   <= sum_nxt_s;
         max_r   <= max_nxt_s;
         zeros_r <= zeros_nxt_s;
      end
   end

   // Summary registers: loaded on close, held until the consumer takes them
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_r <= 1'b0;
         out_sum_r   <= {(DW+4){1'b0}};
         out_max_r   <= {DW{1'b0}};
         out_zeros_r <= 5'd0;
         out_count_r <= 5'd0;
      end else if (close_s) begin
         out_valid_r <= 1'b1;
         out_sum_r   <= sum_nxt_s;
         out_max_r   <= max_nxt_s;
         out_zeros_r <= zeros_nxt_s;
         out_count_r <= cnt_nxt_s;
      end else if (handoff_s) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sum   = out_sum_r;
   assign bus.out_max   = out_max_r;
   assign bus.out_zeros = out_zeros_r;
   assign bus.out_count = out_count_r;

endmodule
